dmem_responder: RTL and testbench

//  Data-memory responder: the memory-side end of the CPU's load/store port.

---
 rtl/mem_pkg.sv | 18 +
 rtl/dmem_array.sv | 43 ++++
 rtl/dmem_responder.sv | 128 ++++++++++++
 tb/tb_dmem_responder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory responder.
//   state_t    : responder FSM states (IDLE, WAIT, RESP)
//   WORD_BYTES : bytes per memory word
//   DATA_W     : word width in bits
//   BE_W       : byte-enable width (one bit per byte lane)
//   CNT_W      : wait-state counter width; holds WAIT_CYCLES+1 for WAIT_CYCLES up to 15
package mem_pkg;
  localparam int WORD_BYTES = 4;
  localparam int DATA_W     = 32;
  localparam int BE_W       = WORD_BYTES;
  localparam int CNT_W      = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;
endpackage

// File: rtl/dmem_array.sv
// Word-wide data RAM with byte-enabled synchronous write and registered read.
// Contents are never reset.
// Ports:
//   clk      : clock, all updates on posedge
//   i_we     : commit write of i_wdata lanes selected by i_be to word i_idx
//   i_re     : capture word i_idx into the read register
//   i_idx    : word index
//   i_wdata  : write data
//   i_be     : byte enables, bit i -> i_wdata[8i+7:8i]
//   o_rdata  : read register, holds its value until the next i_re
module dmem_array
  import mem_pkg::*;
#(
  parameter int IDX_W = 8
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [BE_W-1:0]   i_be,
  output logic [DATA_W-1:0] o_rdata
);
  localparam int DEPTH = 1 << IDX_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (i_be[i]) begin
          r_mem[i_idx][8*i +: 8] <= i_wdata[8*i +: 8];
        end
      end
    end
    if (i_re) begin
      r_rdata <= r_mem[i_idx];
    end
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: memory-side end of the CPU load/store port.
// One request at a time over valid/ready; the read or byte-masked write is
// performed after WAIT_CYCLES wait states and the result is returned over a
// valid/ready response channel.
// Optional feature macro: DMEM_ALIGN_CHECK_EN -- when defined, a request with
// req_addr[1:0] != 0 is rejected with rsp_err=1 (no write, rdata 0).
// Ports:
//   clk        : clock
//   rst        : synchronous active-low reset
//   req_valid  : request present
//   req_ready  : responder can accept a request
//   req_we     : 1 = write, 0 = read
//   req_addr   : byte address
//   req_wdata  : write data
//   req_be     : byte enables
//   rsp_valid  : response present
//   rsp_ready  : initiator accepts response
//   rsp_rdata  : read data (0 for writes and errors)
//   rsp_err    : request rejected (out of range, or misaligned with the macro)
module dmem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);
  localparam int IDX_W = ADDR_WIDTH - 2;
  // WAIT always lasts WAIT_CYCLES+1 edges so that the response appears
  // WAIT_CYCLES+1 edges after the accept edge, including WAIT_CYCLES==0.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES + 1);

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_we;
  logic [31:0]       r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [BE_W-1:0]   r_be;

  logic              w_accept;
  logic              w_access;
  logic              w_range_err;
  logic              w_align_err;
  logic              w_err;
  logic [DATA_W-1:0] w_arr_rdata;

  assign req_ready = rst && (r_state == IDLE);
  assign w_accept  = req_valid && req_ready;

  // Access happens on the edge that moves WAIT -> RESP; gating with rst keeps
  // a write that is hit by reset on that very edge from committing.
  assign w_access  = rst && (r_state == WAIT) && (r_cnt <= CNT_W'(1));

  // Checks work on the latched address, which stays stable through RESP.
  assign w_range_err = |r_addr[31:ADDR_WIDTH];
`ifdef DMEM_ALIGN_CHECK_EN
  assign w_align_err = |r_addr[1:0];
`else
  logic w_unused_addr_lsb;
  assign w_unused_addr_lsb = ^r_addr[1:0];
  assign w_align_err = 1'b0;
`endif
  assign w_err = w_range_err || w_align_err;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_accept) w_next = WAIT;
      WAIT: if (r_cnt <= CNT_W'(1)) w_next = RESP;
      RESP: if (rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_cnt <= CNT_LOAD;
      end else if ((r_state == WAIT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  // Request latch carries no reset: it is only observed after an accept.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we    <= req_we;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
      r_be    <= req_be;
    end
  end

  dmem_array #(
    .IDX_W (IDX_W)
  ) u_array (
    .clk     (clk),
    .i_we    (w_access && r_we && !w_err),
    .i_re    (w_access && !r_we && !w_err),
    .i_idx   (r_addr[ADDR_WIDTH-1:2]),
    .i_wdata (r_wdata),
    .i_be    (r_be),
    .o_rdata (w_arr_rdata)
  );

  // The array read register only changes on an access edge, so the read
  // data stays stable for the whole RESP state.
  assign rsp_valid = (r_state == RESP);
  assign rsp_err   = (r_state == RESP) && w_err;
  assign rsp_rdata = ((r_state == RESP) && !r_we && !w_err) ? w_arr_rdata : '0;
endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
  localparam int AW = 10;
  localparam int WC = 2;
  localparam int TMO = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        rsp_ready = 1'b0;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int tests = 0;
  int fails = 0;

  // Reference memory: one word per index, plus a flag for words with known content.
  logic [31:0] model [256];
  bit          known [256];

  dmem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(WC)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  function automatic bit exp_err(input logic [31:0] a);
    bit e;
    e = (a >= 32'(1 << AW));
`ifdef DMEM_ALIGN_CHECK_EN
    if (a % 4 != 0) e = 1'b1;
`endif
    return e;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a % (1 << AW)) / 4);
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
    int k;
    if (exp_err(a)) return;
    k = widx(a);
    for (int i = 0; i < 4; i++)
      if (be[i]) model[k][8*i +: 8] = wd[8*i +: 8];
    if (be == 4'hF) known[k] = 1'b1;
  endtask

  // One full request/response exchange with rsp_ready held high.
  // lat counts edges from the accept edge until rsp_valid is seen.
  task automatic txn(input logic we, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] be, output logic [31:0] rd, output logic er,
                     output int lat, output bit to);
    int n;
    to = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_be = be;
    n = 0;
    while (!req_ready && n < TMO) begin @(negedge clk); n++; end
    if (n >= TMO) to = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = $urandom; req_addr = $urandom; req_wdata = $urandom; req_be = $urandom;
    lat = 0;
    while (!rsp_valid && lat < TMO) begin @(posedge clk); #1; lat++; end
    if (lat >= TMO) to = 1'b1;
    rd = rsp_rdata; er = rsp_err;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL reset_req_ready got %b want 0", req_ready); end
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    tests++; if (rsp_rdata !== 32'h0) begin fails++; $display("FAIL reset_rsp_rdata got %h want 0", rsp_rdata); end
    tests++; if (rsp_err !== 1'b0) begin fails++; $display("FAIL reset_rsp_err got %b want 0", rsp_err); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL release_req_ready got %b want 1", req_ready); end
  endtask

  task automatic test_write_read;
    logic [31:0] rd; logic er; int lat; bit to;
    txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat, to);
    model_write(32'h10, 32'hDEADBEEF, 4'hF);
    tests++; if (to || er !== 1'b0 || rd !== 32'h0) begin fails++; $display("FAIL wr_rsp got err=%b rdata=%h to=%0d want err=0 rdata=0", er, rd, to); end
    tests++; if (lat != WC + 1) begin fails++; $display("FAIL wr_latency got %0d want %0d", lat, WC + 1); end
    txn(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, to);
    tests++; if (to || er !== 1'b0 || rd !== 32'hDEADBEEF) begin fails++; $display("FAIL rd_rsp got err=%b rdata=%h want err=0 rdata=deadbeef", er, rd); end
    tests++; if (lat != WC + 1) begin fails++; $display("FAIL rd_latency got %0d want %0d", lat, WC + 1); end
  endtask

  task automatic test_byte_enable;
    logic [31:0] rd; logic er; int lat; bit to;
    txn(1'b1, 32'h10, 32'h000000AA, 4'b0001, rd, er, lat, to);
    model_write(32'h10, 32'h000000AA, 4'b0001);
    txn(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, to);
    tests++; if (to || rd !== 32'hDEADBEAA) begin fails++; $display("FAIL be_0001 got %h want deadbeaa", rd); end
    txn(1'b1, 32'h10, 32'h12345678, 4'b0000, rd, er, lat, to);
    tests++; if (to || er !== 1'b0 || rd !== 32'h0) begin fails++; $display("FAIL be_0000_rsp got err=%b rdata=%h want 0/0", er, rd); end
    txn(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, to);
    tests++; if (to || rd !== 32'hDEADBEAA) begin fails++; $display("FAIL be_0000_noop got %h want deadbeaa", rd); end
  endtask

  task automatic test_out_of_range;
    logic [31:0] rd; logic er; int lat; bit to;
    txn(1'b1, 32'h04, 32'h01020304, 4'hF, rd, er, lat, to);
    model_write(32'h04, 32'h01020304, 4'hF);
    txn(1'b0, 32'h400, 32'h0, 4'h0, rd, er, lat, to);
    tests++; if (to || er !== 1'b1 || rd !== 32'h0) begin fails++; $display("FAIL oor_read got err=%b rdata=%h want err=1 rdata=0", er, rd); end
    tests++; if (lat != WC + 1) begin fails++; $display("FAIL oor_latency got %0d want %0d", lat, WC + 1); end
    txn(1'b1, 32'h404, 32'hFFFFFFFF, 4'hF, rd, er, lat, to);
    tests++; if (to || er !== 1'b1) begin fails++; $display("FAIL oor_write_err got %b want 1", er); end
    txn(1'b0, 32'h04, 32'h0, 4'h0, rd, er, lat, to);
    tests++; if (to || rd !== 32'h01020304) begin fails++; $display("FAIL oor_no_alias got %h want 01020304", rd); end
  endtask

  task automatic test_backpressure;
    logic [31:0] rd, hold_rd; logic er, hold_er; int n, lat; bit to;
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_wdata = '0; req_be = '0;
    n = 0;
    while (!req_ready && n < TMO) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < TMO) begin @(posedge clk); #1; n++; end
    tests++; if (n >= TMO) begin fails++; $display("FAIL bp_rsp_timeout got %0d cycles want rsp_valid", n); end
    hold_rd = rsp_rdata; hold_er = rsp_err;
    tests++; if (hold_rd !== 32'hDEADBEAA || hold_er !== 1'b0) begin fails++; $display("FAIL bp_rdata got %h/%b want deadbeaa/0", hold_rd, hold_er); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      req_valid = (c == 2); req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h0; req_be = 4'hF;
      @(posedge clk); #1;
      tests++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== hold_rd || rsp_err !== hold_er || req_ready !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold cycle %0d got v=%b d=%h e=%b rdy=%b want v=1 d=%h e=%b rdy=0",
                 c, rsp_valid, rsp_rdata, rsp_err, req_ready, hold_rd, hold_er);
      end
    end
    @(negedge clk); req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    tests++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin fails++; $display("FAIL bp_release got v=%b rdy=%b want 0/1", rsp_valid, req_ready); end
    txn(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, to);
    tests++; if (to || rd !== 32'hDEADBEAA) begin fails++; $display("FAIL bp_pulse_ignored got %h want deadbeaa", rd); end
  endtask

  task automatic test_reset_mid_write;
    logic [31:0] rd; logic er; int n, lat; bit to, seen;
    txn(1'b1, 32'h20, 32'h5A5A0000, 4'hF, rd, er, lat, to);
    model_write(32'h20, 32'h5A5A0000, 4'hF);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h11111111; req_be = 4'hF;
    n = 0;
    while (!req_ready && n < TMO) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    req_valid = 1'b0; rst = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin @(posedge clk); #1; if (rsp_valid) seen = 1'b1; end
    tests++; if (seen) begin fails++; $display("FAIL midrst_no_rsp got rsp_valid=1 want 0"); end
    txn(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat, to);
    tests++; if (to || rd !== 32'h5A5A0000) begin fails++; $display("FAIL midrst_old_data got %h want 5a5a0000", rd); end
  endtask

  task automatic test_alignment;
    logic [31:0] rd; logic er; int lat; bit to;
    txn(1'b0, 32'h11, 32'h0, 4'h0, rd, er, lat, to);
`ifdef DMEM_ALIGN_CHECK_EN
    tests++; if (to || er !== 1'b1 || rd !== 32'h0) begin fails++; $display("FAIL align_err got err=%b rdata=%h want 1/0", er, rd); end
`else
    tests++; if (to || er !== 1'b0 || rd !== 32'hDEADBEAA) begin fails++; $display("FAIL align_word got err=%b rdata=%h want 0/deadbeaa", er, rd); end
`endif
    tests++; if (lat != WC + 1) begin fails++; $display("FAIL align_latency got %0d want %0d", lat, WC + 1); end
  endtask

  task automatic test_random;
    logic [31:0] rd, a, wd, exp_rd; logic er, we; logic [3:0] be; int lat, k; bit to, ee;
    for (int i = 0; i < 16; i++) begin
      wd = $urandom;
      txn(1'b1, 32'(i * 4), wd, 4'hF, rd, er, lat, to);
      model_write(32'(i * 4), wd, 4'hF);
    end
    for (int t = 0; t < 60; t++) begin
      we = $urandom_range(0, 1);
      a  = 32'($urandom_range(0, 15) * 4);
      if ($urandom_range(0, 5) == 0) a = a + 32'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) a = a | (32'h1 << $urandom_range(AW, 31));
      wd = $urandom; be = 4'($urandom);
      ee = exp_err(a);
      k  = widx(a);
      exp_rd = (we || ee) ? 32'h0 : model[k];
      txn(we, a, wd, be, rd, er, lat, to);
      if (we) model_write(a, wd, be);
      tests++;
      if (to || er !== ee || lat != WC + 1 || (known[k] && rd !== exp_rd)) begin
        fails++;
        $display("FAIL rand_%0d we=%b addr=%h got err=%b rdata=%h lat=%0d want err=%b rdata=%h lat=%0d",
                 t, we, a, er, rd, lat, ee, exp_rd, WC + 1);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin model[i] = '0; known[i] = 1'b0; end
    test_reset();
    test_write_read();
    test_byte_enable();
    test_out_of_range();
    test_backpressure();
    test_reset_mid_write();
    test_alignment();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
